// File: rtl/hqm_AW_pkg.sv
// rtl/hqm_AW_pkg.sv - shared types and helpers for the LIFO memory responder
package hqm_AW_pkg;

  typedef enum logic {HQM_AW_LIFOMEM_INIT, HQM_AW_LIFOMEM_IDLE} aw_lifomem_state_t;

  // floor(log2(value)); value 0 or 1 yields 0
  function automatic int AW_logb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 1; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/hqm_aw_lifo_mem_rf.sv
// rtl/hqm_aw_lifo_mem_rf.sv - flop array, one write port, one registered read port
module hqm_aw_lifo_mem_rf #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 16,
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // storage is deliberately not reset; the init sequencer clears it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hqm_aw_lifo_mem_rsp.sv
// rtl/hqm_aw_lifo_mem_rsp.sv - LIFO memory responder with init sequencer; parity via HQM_AW_LIFO_MEM_PAR_EN
module hqm_aw_lifo_mem_rsp
  import hqm_AW_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWIDTH  = 16,
  parameter int DEPTHB2 = AW_logb2(DEPTH-1)+1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_re,
  input  logic               mem_we,
  input  logic [DEPTHB2-1:0] mem_addr,
  input  logic [DWIDTH-1:0]  mem_wdata,
  output logic [DWIDTH-1:0]  mem_rdata,
  input  logic               init_req,
  output logic               init_done,
  output logic               status_idle,
`ifdef HQM_AW_LIFO_MEM_PAR_EN
  input  logic               cfg_par_inj,
  output logic               error_par,
`endif
  output logic               error_collision,
  output logic               error_addr,
  output logic               error_busy
);

`ifdef HQM_AW_LIFO_MEM_PAR_EN
  localparam int RW = DWIDTH + 1;
`else
  localparam int RW = DWIDTH;
`endif

  aw_lifomem_state_t  state, state_nxt;
  logic [DEPTHB2-1:0] init_cnt, init_cnt_nxt;
  logic               idle, addr_ok, acc_we, acc_re;
  logic               rf_we;
  logic [DEPTHB2-1:0] rf_waddr;
  logic [RW-1:0]      rf_wdata, wr_word, rf_rdata;

  // a power-of-two depth can never see an out-of-range address
  generate
    if ((1 << DEPTHB2) == DEPTH) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign addr_ok = (int'(mem_addr) < DEPTH);
    end
  endgenerate

  assign idle        = (state == HQM_AW_LIFOMEM_IDLE);
  assign acc_we      = idle & mem_we & addr_ok;
  assign acc_re      = idle & mem_re & ~mem_we & addr_ok;
  assign init_done   = idle;
  assign status_idle = idle & ~mem_re & ~mem_we;

`ifdef HQM_AW_LIFO_MEM_PAR_EN
  assign wr_word = {(^mem_wdata) ^ cfg_par_inj, mem_wdata};
`else
  assign wr_word = mem_wdata;
`endif

  assign rf_we    = idle ? acc_we : 1'b1;
  assign rf_waddr = idle ? mem_addr : init_cnt;
  assign rf_wdata = idle ? wr_word : '0;

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    if (state == HQM_AW_LIFOMEM_INIT) begin
      init_cnt_nxt = init_cnt + 1'b1;
      if (init_cnt == DEPTHB2'(DEPTH-1)) begin
        state_nxt    = HQM_AW_LIFOMEM_IDLE;
        init_cnt_nxt = '0;
      end
    end else if (init_req) begin
      state_nxt    = HQM_AW_LIFOMEM_INIT;
      init_cnt_nxt = '0;
    end
  end

`ifdef HQM_AW_LIFO_MEM_PAR_EN
  logic rd_vld;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= HQM_AW_LIFOMEM_INIT;
      init_cnt        <= '0;
      error_collision <= 1'b0;
      error_addr      <= 1'b0;
      error_busy      <= 1'b0;
`ifdef HQM_AW_LIFO_MEM_PAR_EN
      rd_vld          <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      init_cnt        <= init_cnt_nxt;
      error_collision <= mem_re & mem_we;
      error_addr      <= (mem_re | mem_we) & ~addr_ok;
      error_busy      <= (mem_re | mem_we) & ~idle;
`ifdef HQM_AW_LIFO_MEM_PAR_EN
      rd_vld          <= acc_re;
`endif
    end
  end

  hqm_aw_lifo_mem_rf #(
    .DEPTH  (DEPTH),
    .WIDTH  (RW),
    .AWIDTH (DEPTHB2)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .re    (acc_re),
    .raddr (mem_addr),
    .rdata (rf_rdata)
  );

  assign mem_rdata = rf_rdata[DWIDTH-1:0];

`ifdef HQM_AW_LIFO_MEM_PAR_EN
  // whole stored word including parity bit must XOR to zero
  assign error_par = rd_vld & (^rf_rdata);
`endif

endmodule
